pwm_capture: RTL and testbench

- Receive-side counterpart of the team's PWM generators. Measures period and high time of an incoming PWM waveform, in system clock cycles.
- Reports a fresh result once per input period. Flags stuck-at-0 and stuck-at-1 (0 % / 100 % duty) inputs via a timeout.
- Used for fan tachometer/PWM loopback checking and for reading external PWM commands.

---
 rtl/pwm_capture_if.sv | 16 +
 rtl/pwm_capture.sv | 210 +++++++++++++++++++++
 tb/tb_pwm_capture.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/pwm_capture_if.sv
// Result bundle of pwm_capture: measurement, timeout status and optional duty percentage.
// The capture block drives it through the master modport; consumers use slave.
interface pwm_capture_if #(
  parameter int CNT_W = 21
);
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             timeout;
  logic             stuck_level;
  logic [6:0]       duty_pct;
  logic             pct_valid;

  modport master (output period, high_time, meas_valid, timeout, stuck_level, duty_pct, pct_valid);
  modport slave  (input  period, high_time, meas_valid, timeout, stuck_level, duty_pct, pct_valid);
endinterface

// File: rtl/pwm_capture.sv
// PWM input capture: measures period/high time in clk cycles and flags stuck inputs by timeout.
// Optional duty-percent divider is built when PWM_CAPTURE_DUTY_PCT_EN is defined.
module pwm_capture #(
  parameter int CNT_W       = 21,
  parameter int TIMEOUT     = 2_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  input  logic          pwm_in,
  pwm_capture_if.master res
);
  typedef enum logic [1:0] {IDLE, ARM, MEAS_HIGH, MEAS_LOW} state_e;

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s_d_q, s_d_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       high_reg_q, high_reg_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic [CNT_W-1:0]       high_time_q, high_time_d;
  logic                   meas_valid_q, meas_valid_d;
  logic                   timeout_q, timeout_d;
  logic                   stuck_q, stuck_d;
  logic                   s, rise, fall, to_hit, do_to, do_res;

  assign s      = sync_q[SYNC_STAGES-1];
  assign rise   = s & ~s_d_q;
  assign fall   = ~s & s_d_q;
  assign to_hit = (cnt_q == TO_CNT);

  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], pwm_in};
    s_d_d        = s;
    state_d      = state_q;
    cnt_d        = cnt_q + ONE;
    high_reg_d   = high_reg_q;
    period_d     = period_q;
    high_time_d  = high_time_q;
    meas_valid_d = 1'b0;
    timeout_d    = timeout_q;
    stuck_d      = stuck_q;
    do_to        = 1'b0;
    do_res       = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d   = '0;
          state_d = ARM;
        end
        ARM: begin
          if (rise) begin
            cnt_d   = ONE;
            state_d = MEAS_HIGH;
          end else if (to_hit) begin
            do_to = 1'b1;
          end
        end
        MEAS_HIGH: begin
          // a fall on the timeout cycle still completes the high phase
          if (fall) begin
            high_reg_d = cnt_q;
            state_d    = MEAS_LOW;
          end else if (to_hit) begin
            do_to = 1'b1;
          end
        end
        MEAS_LOW: begin
          if (rise) begin
            do_res  = 1'b1;
            cnt_d   = ONE;
            state_d = MEAS_HIGH;
          end else if (to_hit) begin
            do_to = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (do_res) begin
      period_d     = cnt_q;
      high_time_d  = high_reg_q;
      meas_valid_d = 1'b1;
      timeout_d    = 1'b0;
    end
    if (do_to) begin
      period_d     = '0;
      high_time_d  = '0;
      meas_valid_d = 1'b1;
      timeout_d    = 1'b1;
      stuck_d      = s;
      cnt_d        = '0;
      state_d      = ARM;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      sync_q       <= '0;
      s_d_q        <= 1'b0;
      cnt_q        <= '0;
      high_reg_q   <= '0;
      period_q     <= '0;
      high_time_q  <= '0;
      meas_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
      stuck_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      s_d_q        <= s_d_d;
      cnt_q        <= cnt_d;
      high_reg_q   <= high_reg_d;
      period_q     <= period_d;
      high_time_q  <= high_time_d;
      meas_valid_q <= meas_valid_d;
      timeout_q    <= timeout_d;
      stuck_q      <= stuck_d;
    end
  end

  assign res.period      = period_q;
  assign res.high_time   = high_time_q;
  assign res.meas_valid  = meas_valid_q;
  assign res.timeout     = timeout_q;
  assign res.stuck_level = stuck_q;

`ifdef PWM_CAPTURE_DUTY_PCT_EN
  // Restoring divider: div_num_q shifts the dividend out the top and the quotient in the bottom.
  localparam int NW     = CNT_W + 7;
  localparam int STEP_W = $clog2(NW + 1);

  logic              div_busy_q, div_busy_d;
  logic [STEP_W-1:0] div_step_q, div_step_d;
  logic [NW-1:0]     div_num_q, div_num_d, num_nx;
  logic [CNT_W:0]    div_rem_q, div_rem_d, rem_sh, rem_nx;
  logic [CNT_W-1:0]  div_den_q, div_den_d;
  logic [6:0]        duty_q, duty_d;
  logic              pct_valid_q, pct_valid_d;
  logic              ge;

  always_comb begin
    rem_sh      = {div_rem_q[CNT_W-1:0], div_num_q[NW-1]};
    ge          = (rem_sh >= {1'b0, div_den_q});
    rem_nx      = ge ? (rem_sh - {1'b0, div_den_q}) : rem_sh;
    num_nx      = {div_num_q[NW-2:0], ge};
    div_busy_d  = div_busy_q;
    div_step_d  = div_step_q;
    div_num_d   = div_num_q;
    div_rem_d   = div_rem_q;
    div_den_d   = div_den_q;
    duty_d      = duty_q;
    pct_valid_d = 1'b0;
    if (do_to) begin
      duty_d      = s ? 7'd100 : 7'd0;
      pct_valid_d = 1'b1;
      div_busy_d  = 1'b0;
    end else if (do_res) begin
      div_busy_d = 1'b1;
      div_step_d = '0;
      div_num_d  = NW'(high_time_d) * NW'(100);
      div_rem_d  = '0;
      div_den_d  = period_d;
    end else if (div_busy_q) begin
      div_num_d  = num_nx;
      div_rem_d  = rem_nx;
      div_step_d = div_step_q + STEP_W'(1);
      if (div_step_q == STEP_W'(NW - 1)) begin
        div_busy_d  = 1'b0;
        duty_d      = num_nx[6:0];
        pct_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_busy_q  <= 1'b0;
      div_step_q  <= '0;
      div_num_q   <= '0;
      div_rem_q   <= '0;
      div_den_q   <= '0;
      duty_q      <= '0;
      pct_valid_q <= 1'b0;
    end else begin
      div_busy_q  <= div_busy_d;
      div_step_q  <= div_step_d;
      div_num_q   <= div_num_d;
      div_rem_q   <= div_rem_d;
      div_den_q   <= div_den_d;
      duty_q      <= duty_d;
      pct_valid_q <= pct_valid_d;
    end
  end

  assign res.duty_pct  = duty_q;
  assign res.pct_valid = pct_valid_q;
`else
  assign res.duty_pct  = 7'd0;
  assign res.pct_valid = 1'b0;
`endif
endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: expected results are queued as edges are driven and
// checked when meas_valid / pct_valid appear.
module tb_pwm_capture;
  localparam int CNT_W   = 21;
  localparam int TIMEOUT = 1000;

  typedef struct {
    int p;
    int h;
    bit to;
    bit st;
    int cyc;
  } exp_t;

  logic clk, reset_n, enable, pwm_in;
  int   cyc = 0;
  int   ncmp = 0;
  int   nfail = 0;
  exp_t sbq[$];
  bit   pend_v = 0;
  int   pend_duty = 0;
  int   pend_cyc = 0;

  pwm_capture_if #(.CNT_W(CNT_W)) rif ();

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .SYNC_STAGES(2)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .enable (enable),
    .pwm_in (pwm_in),
    .res    (rif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    ncmp++;
    assert (got === want) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic wcyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int p, input int h, input bit to, input bit st, input int dcyc);
    exp_t e;
    e.p = p; e.h = h; e.to = to; e.st = st; e.cyc = cyc + dcyc;
    sbq.push_back(e);
  endtask

  // One high/low pulse; when ex is set the rising edge completes a period of (ep, eh)
  task automatic pulse(input int h, input int l, input bit ex, input int ep, input int eh);
    if (ex) push(ep, eh, 1'b0, 1'b0, 3);
    pwm_in = 1'b1;
    wcyc(h);
    pwm_in = 1'b0;
    wcyc(l);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_period"}, 32'(rif.period), 0);
    chk({tag, "_high"}, 32'(rif.high_time), 0);
    chk({tag, "_valid"}, 32'(rif.meas_valid), 0);
    chk({tag, "_timeout"}, 32'(rif.timeout), 0);
    chk({tag, "_stuck"}, 32'(rif.stuck_level), 0);
    chk({tag, "_duty"}, 32'(rif.duty_pct), 0);
  endtask

  // Monitor: pop one expectation per meas_valid, track the pending duty result
  always @(negedge clk) begin
    exp_t e;
    if (rif.meas_valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_meas_valid", 32'(1), 32'(0));
      end else begin
        e = sbq.pop_front();
        chk("meas_cycle", 32'(cyc), 32'(e.cyc));
        chk("period", 32'(rif.period), 32'(e.p));
        chk("high_time", 32'(rif.high_time), 32'(e.h));
        chk("timeout", 32'(rif.timeout), 32'(e.to));
        if (e.to) chk("stuck_level", 32'(rif.stuck_level), 32'(e.st));
`ifdef PWM_CAPTURE_DUTY_PCT_EN
        pend_v = 1'b1;
        if (e.to) begin
          pend_duty = e.st ? 100 : 0;
          pend_cyc  = cyc;
        end else begin
          pend_duty = (e.h * 100) / e.p;
          pend_cyc  = cyc + CNT_W + 7;
        end
`else
        chk("duty_tied", 32'(rif.duty_pct), 32'(0));
        chk("pct_valid_tied", 32'(rif.pct_valid), 32'(0));
`endif
      end
    end
`ifdef PWM_CAPTURE_DUTY_PCT_EN
    if (rif.pct_valid) begin
      chk("pct_expected", 32'(pend_v), 32'(1));
      if (pend_v) begin
        chk("duty_pct", 32'(rif.duty_pct), 32'(pend_duty));
        chk("pct_cycle", 32'(cyc), 32'(pend_cyc));
        pend_v = 1'b0;
      end
    end
`endif
  end

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    pwm_in  = 1'b0;
    wcyc(1);
    // reset held while the input toggles
    for (int i = 0; i < 5; i++) begin
      pwm_in = 1'b1; wcyc(2);
      pwm_in = 1'b0; wcyc(2);
    end
    chk_zero("in_reset");
    reset_n = 1'b1;
    // enabled off: input activity must not produce results
    for (int i = 0; i < 30; i++) pulse(5, 5, 1'b0, 0, 0);
    chk_zero("disabled");

    // steady 30/70
    enable = 1'b1;
    wcyc(3);
    pulse(30, 70, 1'b0, 0, 0);
    for (int i = 0; i < 4; i++) pulse(30, 70, 1'b1, 100, 30);

    // minimum pulse: first rise closes the last 30/70 period
    pulse(1, 1, 1'b1, 100, 30);
    for (int i = 0; i < 8; i++) pulse(1, 1, 1'b1, 2, 1);

    // stuck high: one result, then timeouts every TIMEOUT+1 cycles
    push(2, 1, 1'b0, 1'b0, 3);
    push(0, 0, 1'b1, 1'b1, TIMEOUT + 3);
    push(0, 0, 1'b1, 1'b1, 2 * TIMEOUT + 4);
    pwm_in = 1'b1;
    wcyc(1500);
    chk("stuck_timeout_level", 32'(rif.timeout), 32'(1));
    chk("stuck_period_zero", 32'(rif.period), 32'(0));
    chk("stuck_level_one", 32'(rif.stuck_level), 32'(1));
    wcyc(550);
    pwm_in = 1'b0;
    wcyc(40);
    // recovery needs two rises
    pulse(20, 40, 1'b0, 0, 0);
    pulse(20, 40, 1'b1, 60, 20);
    chk("timeout_cleared", 32'(rif.timeout), 32'(0));

    // enable dropped mid-high: that period is discarded
    push(60, 20, 1'b0, 1'b0, 3);
    pwm_in = 1'b1;
    wcyc(10);
    enable = 1'b0;
    wcyc(5);
    enable = 1'b1;
    wcyc(5);
    pwm_in = 1'b0;
    wcyc(40);
    pulse(20, 40, 1'b0, 0, 0);
    pulse(20, 40, 1'b1, 60, 20);

    // reset pulsed during the low phase
    push(60, 20, 1'b0, 1'b0, 3);
    pwm_in = 1'b1;
    wcyc(20);
    pwm_in = 1'b0;
    wcyc(20);
    reset_n = 1'b0;
    #1;
    chk_zero("async_reset");
    wcyc(3);
    reset_n = 1'b1;
    wcyc(3);
    pulse(25, 50, 1'b0, 0, 0);
    pulse(25, 50, 1'b1, 75, 25);
    pulse(25, 50, 1'b1, 75, 25);
    wcyc(60);

    chk("scoreboard_drained", 32'(sbq.size()), 32'(0));
`ifdef PWM_CAPTURE_DUTY_PCT_EN
    chk("duty_drained", 32'(pend_v), 32'(0));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
